// File: rtl/serial_feeder.sv
// Parallel-to-serial feeder: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one registered bit per clock, MSB-first or
// LSB-first, with a pause that freezes the stream and a completed-word counter.

module serial_feeder #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             lsb_first,
    input  logic             pause,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last_bit,
    output logic             busy,
    output logic [7:0]       word_cnt
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Remaining bits of the word; the next bit to emit always sits at the
    // end selected by lsb_r, so emission is a fixed-position read plus a shift.
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [IW-1:0]    bit_idx;
    logic [IW-1:0]    bit_idx_nxt;
    logic [IW-1:0]    idx_inc;
    logic             lsb_r;
    logic             lsb_nxt;
    logic             ser_out_nxt;
    logic             ser_valid_nxt;
    logic             last_bit_nxt;
    logic             busy_nxt;
    logic [7:0]       word_cnt_nxt;
    logic             at_last;
    logic             accept;

    assign at_last = (bit_idx == LAST_IDX);
    assign idx_inc = bit_idx + IW'(1);
    assign accept  = din_valid && din_ready;

    // Ready is open while idle, or on the final bit of an unpaused word so
    // that a waiting word follows with no gap bit.
    always_comb begin
        din_ready = 1'b0;
        if (rst) begin
            if (state == IDLE) begin
                din_ready = 1'b1;
            end else if (state == SHIFT && at_last && !pause) begin
                din_ready = 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; releasing a pause that began on the final bit ends the
    // word, because that bit was already delivered as valid.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (pause) begin
                    state_nxt = HOLD;
                end else if (at_last) begin
                    state_nxt = accept ? SHIFT : IDLE;
                end
            end
            HOLD: begin
                if (!pause) begin
                    state_nxt = at_last ? IDLE : SHIFT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Next values of the registered datapath and outputs for each state.
    always_comb begin
        shreg_nxt     = shreg;
        bit_idx_nxt   = bit_idx;
        lsb_nxt       = lsb_r;
        ser_out_nxt   = ser_out;
        ser_valid_nxt = 1'b0;
        last_bit_nxt  = 1'b0;
        word_cnt_nxt  = word_cnt;
        busy_nxt      = (state_nxt != IDLE);

        case (state)
            IDLE: begin
                ser_out_nxt = IDLE_BIT;
                if (accept) begin
                    lsb_nxt       = lsb_first;
                    bit_idx_nxt   = '0;
                    ser_out_nxt   = lsb_first ? din[0] : din[WIDTH-1];
                    shreg_nxt     = lsb_first ? (din >> 1) : (din << 1);
                    ser_valid_nxt = 1'b1;
                    last_bit_nxt  = (LAST_IDX == '0);
                end
            end
            SHIFT: begin
                if (!pause) begin
                    if (at_last) begin
                        word_cnt_nxt = word_cnt + 8'd1;
                        if (accept) begin
                            lsb_nxt       = lsb_first;
                            bit_idx_nxt   = '0;
                            ser_out_nxt   = lsb_first ? din[0] : din[WIDTH-1];
                            shreg_nxt     = lsb_first ? (din >> 1) : (din << 1);
                            ser_valid_nxt = 1'b1;
                            last_bit_nxt  = (LAST_IDX == '0);
                        end else begin
                            ser_out_nxt = IDLE_BIT;
                            bit_idx_nxt = '0;
                        end
                    end else begin
                        bit_idx_nxt   = idx_inc;
                        ser_out_nxt   = lsb_r ? shreg[0] : shreg[WIDTH-1];
                        shreg_nxt     = lsb_r ? (shreg >> 1) : (shreg << 1);
                        ser_valid_nxt = 1'b1;
                        last_bit_nxt  = (idx_inc == LAST_IDX);
                    end
                end
            end
            HOLD: begin
                if (!pause) begin
                    if (at_last) begin
                        word_cnt_nxt = word_cnt + 8'd1;
                        ser_out_nxt  = IDLE_BIT;
                        bit_idx_nxt  = '0;
                    end else begin
                        bit_idx_nxt   = idx_inc;
                        ser_out_nxt   = lsb_r ? shreg[0] : shreg[WIDTH-1];
                        shreg_nxt     = lsb_r ? (shreg >> 1) : (shreg << 1);
                        ser_valid_nxt = 1'b1;
                        last_bit_nxt  = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: begin
                ser_out_nxt = IDLE_BIT;
            end
        endcase
    end

    // Datapath and output registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg     <= '0;
            bit_idx   <= '0;
            lsb_r     <= 1'b0;
            ser_out   <= IDLE_BIT;
            ser_valid <= 1'b0;
            last_bit  <= 1'b0;
            busy      <= 1'b0;
            word_cnt  <= 8'd0;
        end else begin
            shreg     <= shreg_nxt;
            bit_idx   <= bit_idx_nxt;
            lsb_r     <= lsb_nxt;
            ser_out   <= ser_out_nxt;
            ser_valid <= ser_valid_nxt;
            last_bit  <= last_bit_nxt;
            busy      <= busy_nxt;
            word_cnt  <= word_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_serial_feeder.sv
// Directed bench for serial_feeder (WIDTH=8, IDLE_BIT=0): single words in both
// bit orders, back-to-back words, pause/resume, mid-word reset, counter wrap.

module tb_serial_feeder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             lsb_first;
    logic             pause;
    logic             ser_out;
    logic             ser_valid;
    logic             last_bit;
    logic             busy;
    logic [7:0]       word_cnt;

    int checks;
    int errors;

    serial_feeder #(
        .WIDTH    (WIDTH),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .lsb_first (lsb_first),
        .pause     (pause),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .last_bit  (last_bit),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic l, input logic p);
        din_valid = v;
        din       = d;
        lsb_first = l;
        pause     = p;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag, input logic [7:0] cnt);
        checkOutput({tag, "_valid"}, 32'(ser_valid), 32'd0);
        checkOutput({tag, "_out"}, 32'(ser_out), 32'd0);
        checkOutput({tag, "_last"}, 32'(last_bit), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_cnt"}, 32'(word_cnt), 32'(cnt));
        checkOutput({tag, "_ready"}, 32'(din_ready), 32'd1);
    endtask

    // bits[7] is the first bit on the wire; checks positions first..last,
    // stepping one clock after each, with pause low throughout.
    task automatic runBits(input string tag, input logic [7:0] bits,
                           input int first, input int last);
        for (int i = first; i <= last; i++) begin
            checkOutput($sformatf("%s_out%0d", tag, i), 32'(ser_out), 32'(bits[7-i]));
            checkOutput($sformatf("%s_valid%0d", tag, i), 32'(ser_valid), 32'd1);
            checkOutput($sformatf("%s_last%0d", tag, i), 32'(last_bit), (i == 7) ? 32'd1 : 32'd0);
            checkOutput($sformatf("%s_ready%0d", tag, i), 32'(din_ready), (i == 7) ? 32'd1 : 32'd0);
            checkOutput($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            step();
        end
    endtask

    // Directed sequence of scenarios.
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset state.
        step();
        step();
        checkOutput("rst_valid", 32'(ser_valid), 32'd0);
        checkOutput("rst_out", 32'(ser_out), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_last", 32'(last_bit), 32'd0);
        checkOutput("rst_cnt", 32'(word_cnt), 32'd0);
        checkOutput("rst_ready_low", 32'(din_ready), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst_ready_high", 32'(din_ready), 32'd1);

        // Single word MSB-first; din/lsb_first change after accept.
        applyStimulus(1'b1, 8'b11010000, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        runBits("msb", 8'b11010000, 0, 7);
        checkIdle("msb_end", 8'd1);

        // Single word LSB-first: 0x0B goes out as 1,1,0,1,0,0,0,0.
        applyStimulus(1'b1, 8'b00001011, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0);
        runBits("lsb", 8'b11010000, 0, 7);
        checkIdle("lsb_end", 8'd2);

        // Back-to-back words with din_valid held high.
        applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        runBits("b2b_a", 8'hD0, 0, 7);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        runBits("b2b_b", 8'hFF, 0, 7);
        checkIdle("b2b_end", 8'd4);

        // Pause for three cycles after bit 2 of 0xD0.
        applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        runBits("pz_pre", 8'hD0, 0, 1);
        checkOutput("pz_bit2_out", 32'(ser_out), 32'd0);
        checkOutput("pz_bit2_valid", 32'(ser_valid), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("pz_hold%0d_valid", k), 32'(ser_valid), 32'd0);
            checkOutput($sformatf("pz_hold%0d_out", k), 32'(ser_out), 32'd0);
            checkOutput($sformatf("pz_hold%0d_last", k), 32'(last_bit), 32'd0);
            checkOutput($sformatf("pz_hold%0d_busy", k), 32'(busy), 32'd1);
            checkOutput($sformatf("pz_hold%0d_ready", k), 32'(din_ready), 32'd0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        runBits("pz_post", 8'hD0, 3, 7);
        checkIdle("pz_end", 8'd5);

        // Accept in IDLE with pause high, then reset at bit 4.
        applyStimulus(1'b1, 8'hD0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        runBits("mr", 8'hD0, 0, 3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checkIdle("mr_after", 8'd0);

        // First accept on the first edge with reset released.
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        runBits("post_rst", 8'hA5, 0, 7);
        checkIdle("post_rst_end", 8'd1);

        // Counter wrap over 256 contiguous words.
        rst = 1'b0;
        step();
        rst = 1'b1;
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        step();
        repeat (255 * 8) step();
        checkOutput("wrap_cnt255", 32'(word_cnt), 32'd255);
        checkOutput("wrap_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (7) step();
        checkOutput("wrap_last", 32'(last_bit), 32'd1);
        checkOutput("wrap_cnt_hold", 32'(word_cnt), 32'd255);
        step();
        checkIdle("wrap_end", 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_feeder.md
SERIAL_FEEDER -- requirements
Module: serial_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter IDLE_BIT, default 1'b0, giving the ser_out level whenever no word is being shifted.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-006 The block SHALL have port din_valid, input, 1 bit: din holds a word offered for transfer.
REQ-007 The block SHALL have port din_ready, output, 1 bit: the block will accept din on this edge.
REQ-008 The block SHALL have port lsb_first, input, 1 bit: 1 selects LSB-first order and 0 selects MSB-first order; it is sampled at accept.
REQ-009 The block SHALL have port pause, input, 1 bit: freezes shifting while high.
REQ-010 The block SHALL have port ser_out, output, 1 bit: the registered serial bit, which drives the downstream detector's inp.
REQ-011 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a fresh data bit this cycle.
REQ-012 The block SHALL have port last_bit, output, 1 bit: ser_out is the final bit of the current word.
REQ-013 The block SHALL have port busy, output, 1 bit: the block is in the SHIFT or HOLD state.
REQ-014 The block SHALL have port word_cnt, output, 8 bits: the count of fully shifted words.

Function
REQ-015 The block SHALL implement exactly three states: IDLE, SHIFT and HOLD.
REQ-016 An accept SHALL occur on a rising edge where din_valid=1 and din_ready=1; din and lsb_first are latched at that edge.
REQ-017 din_ready SHALL be combinational and equal to 1 only in these cases:
- state IDLE;
- state SHIFT with bit index = WIDTH-1 and pause=0.
It SHALL be 0 in every other case, and always 0 while rst=0.
REQ-018 In IDLE, an accept SHALL move the block to SHIFT with bit index 0.
- The first data bit appears on ser_out with ser_valid=1 in the cycle after the accept edge, giving a latency of 1 clock.
REQ-019 In SHIFT with pause=0, each edge SHALL advance the bit index by 1 and present the next bit on ser_out with ser_valid=1.
REQ-020 Bit order SHALL be din[WIDTH-1] down to din[0] when the latched lsb_first=0, and din[0] up to din[WIDTH-1] when it is 1.
REQ-021 last_bit SHALL equal 1 exactly while ser_valid=1 and the bit index = WIDTH-1.
REQ-022 On an edge in SHIFT with bit index = WIDTH-1 and pause=0, word_cnt SHALL increment by 1 modulo 256, wrapping 255 to 0. The next state depends on din_valid:
- din_valid=1: accept the new word and present its first bit next cycle, so back-to-back words have no gap bit.
- din_valid=0: go to IDLE; ser_out=IDLE_BIT, ser_valid=0, last_bit=0.
REQ-023 When pause=1 on an edge in SHIFT, the block SHALL go to HOLD.
- ser_out and the bit index hold their values; ser_valid=0 and last_bit=0 for every paused cycle.
REQ-024 In HOLD with pause=0 on an edge, the block SHALL return to SHIFT and present the next bit in sequence with ser_valid=1.
- No bit is skipped or repeated as a valid bit.
REQ-025 pause SHALL have no effect in IDLE, and accepts in IDLE proceed normally.
REQ-026 A change to din or lsb_first after the accept SHALL NOT alter the word being shifted.
REQ-027 busy SHALL be 1 in SHIFT and HOLD and 0 in IDLE.
REQ-028 All outputs except din_ready SHALL be registered.

Reset
REQ-029 On a rising clk edge with rst=0, the block SHALL set:
- state=IDLE;
- ser_out=IDLE_BIT;
- ser_valid=0, last_bit=0, busy=0;
- word_cnt=0;
- bit index=0 and the shift register=0.
REQ-030 A reset mid-word SHALL discard the word, with no word_cnt increment and no further bits of it emitted.
REQ-031 The first accept after rst returns to 1 SHALL be possible on the first edge with rst=1.

Verification
REQ-032 Scenario single word MSB-first: WIDTH=8, accept din=8'b11010000 with lsb_first=0.
- Response: ser_out=1,1,0,1,0,0,0,0 on 8 consecutive cycles with ser_valid=1.
- last_bit=1 on the 8th cycle, then IDLE; word_cnt=1.
REQ-033 Scenario LSB-first: accept din=8'b00001011 with lsb_first=1.
- Response: ser_out=1,1,0,1,0,0,0,0; the downstream detector sees the sequence 11010.
REQ-034 Scenario back-to-back: din_valid held high with two words, 8'hD0 then 8'hFF.
- Response: 16 contiguous valid bits with din_ready=1 only at bit 7; word_cnt=2.
REQ-035 Scenario pause: pause=1 for 3 cycles after bit 2 of 8'hD0.
- Response: ser_valid=0 for 3 cycles with ser_out held at 0.
- The stream then resumes at bit 3 (=1); the total valid bit sequence is unchanged.
REQ-036 Scenario reset mid-word: rst=0 for 1 edge at bit 4.
- Response: the next cycle shows ser_valid=0, ser_out=IDLE_BIT, word_cnt=0, busy=0, din_ready=1.
REQ-037 Scenario counter wrap: shift 256 words.
- Response: word_cnt reads 255, then 0.
